// File: rtl/quad_decoder_if.sv
// ============================================================================
//  Module   : quad_decoder_if
//  Purpose  : Encoder-pin / readout bundle for the quadrature decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface quad_decoder_if #(
  parameter int WIDTH = 16
);
  logic             A;
  logic             B;
  logic             CLR;
  logic             STEP;
  logic             DIR;
  logic [WIDTH-1:0] POS;
  logic             ERR;

  modport master (output A, B, CLR, input STEP, DIR, POS, ERR);
  modport slave  (input A, B, CLR, output STEP, DIR, POS, ERR);
endinterface

`default_nettype wire

// File: rtl/quad_decoder.sv
// ============================================================================
//  Module   : quad_decoder
//  Purpose  : 4x quadrature decoder with synchronizer, wrapping signed position
//             and sticky illegal-transition flag. Define QDEC_FILTER_EN to add a
//             per-phase glitch filter after the synchronizer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_decoder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input wire            C_i,
  input wire            R_i,
  quad_decoder_if.slave bus
);

`ifdef QDEC_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  // Priming waits until the pipeline carries samples taken after reset release.
  localparam int PRIME_DLY = SYNC_STAGES + (FILT_EN ? FILT_LEN : 0);
  localparam int WARM_W    = $clog2(PRIME_DLY + 1);

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [1:0]             sync_w;
  logic [1:0]             cur_w;

  always_ff @(posedge C_i or negedge R_i) begin
    if (!R_i) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.A};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.B};
    end
  end

  assign sync_w = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef QDEC_FILTER_EN
  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge C_i or negedge R_i) begin
      if (!R_i) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else if (sync_w[g] == filt_q) begin
        cnt_q  <= '0;
      end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_q <= sync_w[g];
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end

    assign cur_w[g] = filt_q;
  end
`else
  assign cur_w = sync_w;
`endif

  // Position along the up sequence 00->01->11->10 (Gray to binary).
  function automatic logic [1:0] phase_idx(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  logic [WARM_W-1:0] warm_q;
  logic              primed_q, primed_d;
  logic [1:0]        prev_q, prev_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  pos_q, pos_d;
  logic              err_q, err_d;
  logic [1:0]        delta_w;
  logic              prime_w;

  assign delta_w = phase_idx(cur_w) - phase_idx(prev_q);
  assign prime_w = !primed_q && (warm_q == WARM_W'(PRIME_DLY));

  always_comb begin
    primed_d = primed_q;
    prev_d   = prev_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    err_d    = err_q;
    if (prime_w) begin
      primed_d = 1'b1;
      prev_d   = cur_w;
    end else if (primed_q) begin
      prev_d = cur_w;
      case (delta_w)
        2'd1: begin
          step_d = 1'b1;
          dir_d  = 1'b1;
          pos_d  = pos_q + WIDTH'(1);
        end
        2'd3: begin
          step_d = 1'b1;
          dir_d  = 1'b0;
          pos_d  = pos_q - WIDTH'(1);
        end
        2'd2:    err_d = 1'b1;
        default: ;
      endcase
    end
    // Clear beats a coincident step on POS but STEP/DIR still report it.
    if (bus.CLR) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge C_i or negedge R_i) begin
    if (!R_i) begin
      warm_q   <= '0;
      primed_q <= 1'b0;
      prev_q   <= 2'b00;
      step_q   <= 1'b0;
      dir_q    <= 1'b1;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (warm_q != WARM_W'(PRIME_DLY)) warm_q <= warm_q + WARM_W'(1);
      primed_q <= primed_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

  assign bus.STEP = step_q;
  assign bus.DIR  = dir_q;
  assign bus.POS  = pos_q;
  assign bus.ERR  = err_q;

endmodule

`default_nettype wire
